// File: rtl/rv32imf_apu_responder.sv
// FPU-side end of the core APU interface: forwards granted requests to the FP datapath
// and returns its results in order through a credit-guarded result FIFO.

module rv32imf_apu_responder_chk #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] in_flight,
  input logic [CNT_W-1:0] fifo_cnt,
  input logic             push,
  input logic             pop
);
  // Occupancy bound: the credit rule must keep the FIFO from ever overflowing.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ({1'b0, in_flight} + {1'b0, fifo_cnt} <= (CNT_W+1)'(FIFO_DEPTH))
        else $error("responder occupancy exceeds FIFO_DEPTH");
      assert (!(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))))
        else $error("responder result FIFO overflow");
    end
  end
endmodule

module rv32imf_apu_responder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apu_req_i,
  input  logic [5:0]       apu_op_i,
  input  logic [2:0][31:0] apu_operands_i,
  output logic             apu_gnt_o,
  output logic             apu_rvalid_o,
  output logic [31:0]      apu_result_o,
  output logic [4:0]       apu_flags_o,
  output logic             fpu_in_valid_o,
  input  logic             fpu_in_ready_i,
  output logic [5:0]       fpu_op_o,
  output logic [2:0][31:0] fpu_operands_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [31:0]      fpu_result_i,
  input  logic [4:0]       fpu_status_i,
  output logic             busy_o,
  output logic             err_o
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [36:0]      mem_q [FIFO_DEPTH];
  logic             rvalid_q, err_q;
  logic [31:0]      result_q;
  logic [4:0]       flags_q;

  logic [CNT_W:0] occ_s;
  logic           credit_s, gnt_s, accept_s, spurious_s, pop_s;
  logic [36:0]    head_s;

  assign occ_s      = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  assign credit_s   = occ_s < DEPTH_W;
  assign gnt_s      = apu_req_i & credit_s & fpu_in_ready_i;
  // Legality is judged on the pre-update in_flight, so a same-cycle grant cannot excuse a result.
  assign accept_s   = fpu_out_valid_i & (in_flight_q != {CNT_W{1'b0}});
  assign spurious_s = fpu_out_valid_i & (in_flight_q == {CNT_W{1'b0}});
  assign pop_s      = fifo_cnt_q != {CNT_W{1'b0}};
  assign head_s     = mem_q[rd_ptr_q];

  assign fpu_in_valid_o  = apu_req_i & credit_s;
  assign fpu_op_o        = apu_op_i;
  assign fpu_operands_o  = apu_operands_i;
  assign fpu_out_ready_o = 1'b1;
  assign apu_gnt_o       = gnt_s;
  assign apu_rvalid_o    = rvalid_q;
  assign apu_result_o    = result_q;
  assign apu_flags_o     = flags_q;
  assign err_o           = err_q;
  assign busy_o          = (in_flight_q != {CNT_W{1'b0}}) | pop_s | rvalid_q;

  // Next-state counts for in-flight operations and buffered results.
  always_comb begin
    in_flight_d = in_flight_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (gnt_s && !accept_s) begin
      in_flight_d = in_flight_q + CNT_ONE;
    end else if (accept_s && !gnt_s) begin
      in_flight_d = in_flight_q - CNT_ONE;
    end else begin
      in_flight_d = in_flight_q;
    end
    if (accept_s && !pop_s) begin
      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
    end else if (pop_s && !accept_s) begin
      fifo_cnt_d = fifo_cnt_q - CNT_ONE;
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
  end

  // Control state, pointers, sticky error and the registered return stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= {CNT_W{1'b0}};
      fifo_cnt_q  <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      result_q    <= 32'h0000_0000;
      flags_q     <= 5'h00;
    end else begin
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (accept_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (spurious_s) begin
        err_q <= 1'b1;
      end
      rvalid_q <= pop_s;
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        result_q <= head_s[31:0];
        flags_q  <= head_s[36:32];
      end
    end
  end

  // Result storage, {status, result} per entry.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= {fpu_status_i, fpu_result_i};
    end
  end

  rv32imf_apu_responder_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flight (in_flight_q),
    .fifo_cnt  (fifo_cnt_q),
    .push      (accept_s),
    .pop       (pop_s)
  );
endmodule

// File: tb/tb_rv32imf_apu_responder.sv
// Scoreboard bench: the bench plays the FP datapath, queues each legal result it
// returns, and a monitor compares every apu_rvalid_o pulse against the queue head.

module tb_rv32imf_apu_responder;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             apu_req_i;
  logic [5:0]       apu_op_i;
  logic [2:0][31:0] apu_operands_i;
  logic             apu_gnt_o, apu_rvalid_o;
  logic [31:0]      apu_result_o;
  logic [4:0]       apu_flags_o;
  logic             fpu_in_valid_o, fpu_in_ready_i;
  logic [5:0]       fpu_op_o;
  logic [2:0][31:0] fpu_operands_o;
  logic             fpu_out_valid_i, fpu_out_ready_o;
  logic [31:0]      fpu_result_i;
  logic [4:0]       fpu_status_i;
  logic             busy_o, err_o;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  always #5 clk = ~clk;

  rv32imf_apu_responder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .apu_req_i(apu_req_i), .apu_op_i(apu_op_i), .apu_operands_i(apu_operands_i),
    .apu_gnt_o(apu_gnt_o), .apu_rvalid_o(apu_rvalid_o),
    .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_op_o(fpu_op_o), .fpu_operands_o(fpu_operands_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Drive a datapath result this cycle; legal ones are expected back in order.
  task automatic give(input logic [31:0] r, input logic [4:0] s, input bit legal);
    fpu_out_valid_i = 1'b1;
    fpu_result_i    = r;
    fpu_status_i    = s;
    if (legal) exp_q.push_back({s, r});
  endtask

  // Every return pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && apu_rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("rv_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rv_result", {32'd0, apu_result_o}, {32'd0, mon_e[31:0]});
        chk("rv_flags", {59'd0, apu_flags_o}, {59'd0, mon_e[36:32]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, pulses, first, last;
    rst_n = 1'b0; apu_req_i = 1'b0; apu_op_i = 6'h00; apu_operands_i = '0;
    fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b0; fpu_result_i = 32'h0; fpu_status_i = 5'h0;
    #2;
    chk("rst_rvalid", apu_rvalid_o, 0);
    chk("rst_result", apu_result_o, 0);
    chk("rst_flags", apu_flags_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("out_ready", fpu_out_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op: grant at cycle 0, result at cycle 5, return at cycle 7.
    cyc();
    apu_req_i = 1'b1; apu_op_i = 6'h01;
    apu_operands_i[0] = 32'h3f80_0000; apu_operands_i[1] = 32'h4000_0000; apu_operands_i[2] = 32'h0;
    smp();
    chk("t1_gnt", apu_gnt_o, 1);
    chk("t1_in_valid", fpu_in_valid_o, 1);
    chk("t1_op", fpu_op_o, 6'h01);
    chk("t1_opa", fpu_operands_o[0], 32'h3f80_0000);
    chk("t1_opb", fpu_operands_o[1], 32'h4000_0000);
    cyc();
    apu_req_i = 1'b0;
    smp();
    chk("t1_busy", busy_o, 1);
    for (int i = 0; i < 4; i++) cyc();
    give(32'h4040_0000, 5'h00, 1'b1);
    smp();
    chk("t1_rv_c5", apu_rvalid_o, 0);
    cyc();
    fpu_out_valid_i = 1'b0;
    smp();
    chk("t1_rv_c6", apu_rvalid_o, 0);
    cyc();
    smp();
    chk("t1_rv_c7", apu_rvalid_o, 1);
    cyc();
    smp();
    chk("t1_busy_c8", busy_o, 0);

    // Credit exhaustion: four grants, then one more only after a result drains.
    cyc();
    apu_req_i = 1'b1; apu_op_i = 6'h02;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (apu_gnt_o) grants++;
      if (i == 4) begin
        chk("t2_gnt_off", apu_gnt_o, 0);
        chk("t2_valid_off", fpu_in_valid_o, 0);
      end
      cyc();
    end
    chk("t2_grants", grants, 4);
    give(32'ha5a5_0001, 5'h10, 1'b1);
    smp();
    chk("t2_gnt_r0", apu_gnt_o, 0);
    cyc();
    fpu_out_valid_i = 1'b0;
    smp();
    chk("t2_gnt_r1", apu_gnt_o, 0);
    cyc();
    smp();
    chk("t2_gnt_r2", apu_gnt_o, 1);
    cyc();
    smp();
    chk("t2_gnt_r3", apu_gnt_o, 0);
    cyc();
    apu_req_i = 1'b0;

    // Back-to-back: four results on consecutive cycles, returned contiguously.
    pulses = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) give(32'h11 + 32'(i), 5'(i + 1), 1'b1);
      else fpu_out_valid_i = 1'b0;
      smp();
      if (apu_rvalid_o) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
      cyc();
    end
    chk("t3_pulses", pulses, 4);
    chk("t3_first", first, 2);
    chk("t3_span", last - first, 3);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_busy", busy_o, 0);

    // Grant and accepted result together leave in_flight unchanged.
    apu_req_i = 1'b1;
    smp(); chk("t4_gnt0", apu_gnt_o, 1); cyc();
    smp(); chk("t4_gnt1", apu_gnt_o, 1); cyc();
    give(32'h22, 5'h00, 1'b1);
    smp();
    chk("t4_gnt2", apu_gnt_o, 1);
    cyc();
    apu_req_i = 1'b0; fpu_out_valid_i = 1'b0;
    smp();
    chk("t4_in_flight", dut.in_flight_q, 2);
    chk("t4_fifo_cnt", dut.fifo_cnt_q, 1);
    chk("t4_err", err_o, 0);
    cyc(); give(32'h33, 5'h08, 1'b1);
    cyc(); give(32'h44, 5'h04, 1'b1);
    cyc(); fpu_out_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    smp();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_busy", busy_o, 0);

    // Spurious result: discarded, sticky error from the next cycle.
    cyc();
    give(32'hdead_beef, 5'h1f, 1'b0);
    smp();
    chk("t5_err_same", err_o, 0);
    cyc();
    fpu_out_valid_i = 1'b0;
    smp();
    chk("t5_err_next", err_o, 1);
    for (int i = 0; i < 3; i++) cyc();
    smp();
    chk("t5_err_sticky", err_o, 1);

    // Reset with three ops in flight and one result buffered.
    cyc();
    apu_req_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    apu_req_i = 1'b0;
    give(32'h55, 5'h02, 1'b1);
    cyc();
    fpu_out_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_rvalid", apu_rvalid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    apu_req_i = 1'b1;
    smp();
    chk("t6_gnt_after", apu_gnt_o, 1);
    cyc();
    apu_req_i = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
